// File: rtl/buffer_download_reader.sv
// ----------------------------------------------------------------------------
// buffer_download_reader
//
// Drain side of one camera buffer. When the camera reports that its buffer is
// stable (i_ready_to_download) and the host asks for a download (i_start), the
// block walks the buffer from address 0. Each byte is fetched over the
// buffer's synchronous read port and offered to the host on a valid/ready
// byte stream. A finished download pulses o_done together with o_flush_req so
// the camera can empty its buffer. A cancelled download pulses o_error
// instead. A download is cancelled by a host abort, or by the camera leaving
// its idle state.
//
// Parameters
//   DEPTH   maximum number of entries in one camera buffer
//   ADDR_W  width of read address, fill level and byte count (2**ADDR_W > DEPTH)
//
// Ports
//   i_clk                system clock, all state on the rising edge
//   i_rst                asynchronous, active-high reset
//   i_start              host download request (level, sampled in IDLE)
//   i_abort              host cancel (sampled outside IDLE)
//   i_ready_to_download  camera idle, buffer contents stable
//   i_fill_level         entries currently held in the buffer
//   i_rd_data            buffer read data, valid one cycle after o_rd_en
//   o_rd_addr            buffer read address
//   o_rd_en              one-cycle buffer read strobe
//   o_out_byte           byte offered to the host
//   o_out_valid          o_out_byte valid, held until accepted
//   i_out_ready          host accepts; transfer = valid & ready at posedge
//   o_busy               high whenever a download is in progress
//   o_byte_count         bytes accepted in the current/last download
//   o_done               one-cycle pulse, download complete
//   o_flush_req          one-cycle pulse with o_done, camera empties buffer
//   o_error              one-cycle pulse, download cancelled
// ----------------------------------------------------------------------------
module buffer_download_reader #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ready_to_download,
  input  logic [ADDR_W-1:0] i_fill_level,
  input  logic [7:0]        i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  output logic [7:0]        o_out_byte,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_byte_count,
  output logic              o_done,
  output logic              o_flush_req,
  output logic              o_error
);

  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic [7:0]        r_out_byte;
  logic              r_out_valid;
  logic              r_busy;
  logic [ADDR_W-1:0] r_byte_count;
  logic              r_done;
  logic              r_flush_req;
  logic              r_error;

  logic              w_cancel;
  logic              w_transfer;
  logic [ADDR_W-1:0] w_len_clamped;
  logic [ADDR_W-1:0] w_count_next;

  // A download is abandoned by a host abort, or when the camera stops
  // guaranteeing stable buffer contents.
  assign w_cancel      = i_abort | ~i_ready_to_download;
  assign w_transfer    = r_out_valid & i_out_ready;
  assign w_len_clamped = (i_fill_level > LP_DEPTH) ? LP_DEPTH : i_fill_level;
  assign w_count_next  = r_byte_count + ADDR_W'(1);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below reads the values from before this clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_rd_addr    <= '0;
      r_rd_en      <= 1'b0;
      r_out_byte   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_count <= '0;
      r_done       <= 1'b0;
      r_flush_req  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // Strobes and pulses default low. Only the transition that needs them
      // raises them, which keeps each of them exactly one cycle wide.
      r_rd_en     <= 1'b0;
      r_done      <= 1'b0;
      r_flush_req <= 1'b0;
      r_error     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start && i_ready_to_download) begin
            r_len        <= w_len_clamped;
            r_byte_count <= '0;
            r_rd_addr    <= '0;
            r_busy       <= 1'b1;
            if (w_len_clamped == '0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_flush_req <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_rd_en <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_out_byte  <= i_rd_data;
            r_out_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          // A byte accepted on the cancel edge still reached the host, so it
          // is counted even though the download ends in an error.
          if (w_transfer) begin
            r_byte_count <= w_count_next;
          end
          if (w_cancel) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
          end else if (w_transfer) begin
            r_out_valid <= 1'b0;
            if (w_count_next == r_len) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_flush_req <= 1'b1;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_rd_en   <= 1'b1;
              r_state   <= S_READ;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_addr    = r_rd_addr;
  assign o_rd_en      = r_rd_en;
  assign o_out_byte   = r_out_byte;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = r_busy;
  assign o_byte_count = r_byte_count;
  assign o_done       = r_done;
  assign o_flush_req  = r_flush_req;
  assign o_error      = r_error;

endmodule
